spi_frame_master: RTL and testbench

- SPI mode-0 frame initiator. It is the master-side counterpart of the firmware's spidev frame slave.
- Shifts out one BUFFER_SIZE-bit frame MSB-first on MOSI and simultaneously captures BUFFER_SIZE bits from MISO.
- Accepts the received frame only if its leading 32 bits match RX_HEADER.
- Used in host-emulation benches and in bridge builds where one FPGA drives another Remora board.

---
 rtl/spi_frame_pkg.sv | 20 ++
 rtl/spi_clk_timer.sv | 38 +++
 rtl/spi_frame_master.sv | 204 ++++++++++++++++++++
 tb/tb_spi_frame_master.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame master.
// Holds the FSM state encoding and the default frame header words.
package spi_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_e;

  // Header the remote slave places at the top of every reply frame ("data").
  localparam logic [31:0] RX_HEADER_DEFAULT = 32'h61746164;

  // Header this master places at the top of every outgoing frame ("writ").
  localparam logic [31:0] TX_HEADER_DEFAULT = 32'h74697277;

endpackage

// File: rtl/spi_clk_timer.sv
// Phase timer for the SPI frame master.
// A down-counter loaded with (duration - 1); expire_o is high while the count is zero,
// so a state that loads the timer on entry lasts exactly 'duration' cycles.
module spi_clk_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Reload on request, otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == '0);

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: shifts one BUFFER_SIZE-bit frame out MSB-first on MOSI while
// capturing the same number of bits from MISO, and accepts the reply only if its top
// 32 bits equal RX_HEADER.
// Optional build macro SPIM_ERRCNT_EN adds a saturating 16-bit header-error counter.
module spi_frame_master
  import spi_frame_pkg::*;
#(
  parameter int          BUFFER_SIZE = 400,
  parameter int          CLK_DIV     = 4,
  parameter int          SSEL_GAP    = 8,
  parameter logic [31:0] RX_HEADER   = RX_HEADER_DEFAULT
) (
  input  logic                   sysclk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic                   SPI_SCK,
  output logic                   SPI_SSEL,
  output logic                   SPI_MOSI,
  input  logic                   SPI_MISO,
  output logic [BUFFER_SIZE-1:0] rx_data,
  output logic                   busy,
  output logic                   done,
  output logic                   hdr_err
`ifdef SPIM_ERRCNT_EN
  ,
  output logic [15:0]            err_count
`endif
);

  localparam int BW       = $clog2(BUFFER_SIZE + 1);
  localparam int TMAX     = (CLK_DIV > SSEL_GAP) ? CLK_DIV : SSEL_GAP;
  localparam int TW       = $clog2(TMAX);
  localparam logic [TW-1:0] PHASE_LOAD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(SSEL_GAP - 1);

  state_e                 state_q, state_d;
  logic [BUFFER_SIZE-1:0] txShift_q, txShift_d;
  logic [BUFFER_SIZE-1:0] rxShift_q, rxShift_d;
  logic [BUFFER_SIZE-1:0] rxData_q, rxData_d;
  logic [BW-1:0]          bitCnt_q, bitCnt_d;
  logic                   sck_q, sck_d;
  logic                   ssel_q, ssel_d;
  logic                   mosi_q, mosi_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   hdrErr_q, hdrErr_d;
`ifdef SPIM_ERRCNT_EN
  logic [15:0]            errCnt_q, errCnt_d;
`endif

  logic          timerLoad;
  logic [TW-1:0] timerVal;
  logic          timerExpire;

  spi_clk_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk_i      (sysclk),
    .rst_ni     (rst_n),
    .load_i     (timerLoad),
    .load_val_i (timerVal),
    .expire_o   (timerExpire)
  );

  // Next-state logic: every phase transition also reloads the phase timer, and all
  // pin/flag updates happen on the transition so the pins come straight from registers.
  always_comb begin
    state_d   = state_q;
    txShift_d = txShift_q;
    rxShift_d = rxShift_q;
    rxData_d  = rxData_q;
    bitCnt_d  = bitCnt_q;
    sck_d     = sck_q;
    ssel_d    = ssel_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hdrErr_d  = 1'b0;
`ifdef SPIM_ERRCNT_EN
    errCnt_d  = errCnt_q;
`endif
    timerLoad = 1'b0;
    timerVal  = PHASE_LOAD;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          txShift_d = tx_data;
          mosi_d    = tx_data[BUFFER_SIZE-1];
          bitCnt_d  = '0;
          busy_d    = 1'b1;
          ssel_d    = 1'b0;
          sck_d     = 1'b0;
          timerLoad = 1'b1;
          state_d   = SETUP;
        end
      end

      SETUP, LOW: begin
        if (timerExpire) begin
          // Rising SCK edge: MISO is sampled as SCK goes high.
          sck_d     = 1'b1;
          rxShift_d = {rxShift_q[BUFFER_SIZE-2:0], SPI_MISO};
          bitCnt_d  = bitCnt_q + BW'(1);
          timerLoad = 1'b1;
          state_d   = HIGH;
        end
      end

      HIGH: begin
        if (timerExpire) begin
          sck_d     = 1'b0;
          timerLoad = 1'b1;
          if (bitCnt_q == BW'(BUFFER_SIZE)) begin
            state_d = HOLD;
          end else begin
            txShift_d = txShift_q << 1;
            mosi_d    = txShift_q[BUFFER_SIZE-2];
            state_d   = LOW;
          end
        end
      end

      HOLD: begin
        if (timerExpire) begin
          ssel_d    = 1'b1;
          timerLoad = 1'b1;
          timerVal  = GAP_LOAD;
          state_d   = GAP;
          if (rxShift_q[BUFFER_SIZE-1 -: 32] == RX_HEADER) begin
            rxData_d = rxShift_q;
            done_d   = 1'b1;
          end else begin
            hdrErr_d = 1'b1;
`ifdef SPIM_ERRCNT_EN
            if (errCnt_q != 16'hFFFF) begin
              errCnt_d = errCnt_q + 16'd1;
            end
`endif
          end
        end
      end

      GAP: begin
        if (timerExpire) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops the frame and releases the bus at once.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      txShift_q <= '0;
      rxShift_q <= '0;
      rxData_q  <= '0;
      bitCnt_q  <= '0;
      sck_q     <= 1'b0;
      ssel_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hdrErr_q  <= 1'b0;
`ifdef SPIM_ERRCNT_EN
      errCnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      txShift_q <= txShift_d;
      rxShift_q <= rxShift_d;
      rxData_q  <= rxData_d;
      bitCnt_q  <= bitCnt_d;
      sck_q     <= sck_d;
      ssel_q    <= ssel_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hdrErr_q  <= hdrErr_d;
`ifdef SPIM_ERRCNT_EN
      errCnt_q  <= errCnt_d;
`endif
    end
  end

  assign SPI_SCK  = sck_q;
  assign SPI_SSEL = ssel_q;
  assign SPI_MOSI = mosi_q;
  assign rx_data  = rxData_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hdr_err  = hdrErr_q;
`ifdef SPIM_ERRCNT_EN
  assign err_count = errCnt_q;
`endif

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed self-checking bench for spi_frame_master (64-bit frames, CLK_DIV=2, SSEL_GAP=4).
// A behavioural mode-0 slave drives MISO; counters watch pins and result pulses.
module tb_spi_frame_master;
  import spi_frame_pkg::*;

  localparam int N = 64;

  logic         sysclk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] tx_data;
  logic         SPI_SCK;
  logic         SPI_SSEL;
  logic         SPI_MOSI;
  logic         SPI_MISO;
  logic [N-1:0] rx_data;
  logic         busy;
  logic         done;
  logic         hdr_err;
`ifdef SPIM_ERRCNT_EN
  logic [15:0]  err_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [N-1:0] slaveWord;
  int           slaveIdx;
  logic [N-1:0] mosiCap;
  int           sckRises;
  int           sselFalls;
  int           doneCnt;
  int           hdrErrCnt;
  int           bothCnt;
  int           sselCycles;
  int           busyCycles;

  spi_frame_master #(
    .BUFFER_SIZE (N),
    .CLK_DIV     (2),
    .SSEL_GAP    (4),
    .RX_HEADER   (RX_HEADER_DEFAULT)
  ) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .start    (start),
    .tx_data  (tx_data),
    .SPI_SCK  (SPI_SCK),
    .SPI_SSEL (SPI_SSEL),
    .SPI_MOSI (SPI_MOSI),
    .SPI_MISO (SPI_MISO),
    .rx_data  (rx_data),
    .busy     (busy),
    .done     (done),
    .hdr_err  (hdr_err)
`ifdef SPIM_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  // 10 ns system clock.
  always #5 sysclk = ~sysclk;

  // Slave model: first bit presented on SSEL fall, next bit after each SCK fall.
  always @(negedge SPI_SSEL) begin
    slaveIdx = N - 1;
    SPI_MISO = slaveWord[N-1];
    sselFalls++;
  end

  always @(negedge SPI_SCK) begin
    if (!SPI_SSEL && slaveIdx > 0) begin
      slaveIdx = slaveIdx - 1;
      SPI_MISO = slaveWord[slaveIdx];
    end
  end

  // Capture MOSI at every SCK rise.
  always @(posedge SPI_SCK) begin
    mosiCap = {mosiCap[N-2:0], SPI_MOSI};
    sckRises++;
  end

  // Count result pulses at each system clock edge.
  always @(posedge sysclk) begin
    if (done) doneCnt++;
    if (hdr_err) hdrErrCnt++;
    if (done && hdr_err) bothCnt++;
  end

  task automatic checkOutput(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearCounters();
    sckRises  = 0;
    sselFalls = 0;
    doneCnt   = 0;
    hdrErrCnt = 0;
    mosiCap   = '0;
  endtask

  // Runs one frame from start to busy falling; optionally pulses start with new data mid-frame.
  task automatic applyStimulus(input logic [N-1:0] txWord, input logic [N-1:0] respWord,
                               input int injectAt, input logic [N-1:0] injectData);
    int n;
    @(negedge sysclk);
    clearCounters();
    slaveWord = respWord;
    tx_data   = txWord;
    start     = 1'b1;
    @(posedge sysclk);
    #1;
    start = 1'b0;
    n = 0;
    while (SPI_SSEL == 1'b0 && n < 2000) begin
      @(posedge sysclk);
      #1;
      n++;
      if (n == injectAt) begin
        start   = 1'b1;
        tx_data = injectData;
      end else begin
        start = 1'b0;
      end
    end
    start      = 1'b0;
    sselCycles = n;
    n = 0;
    while (busy == 1'b1 && n < 100) begin
      @(posedge sysclk);
      #1;
      n++;
    end
    busyCycles = n;
    repeat (2) @(posedge sysclk);
    #1;
  endtask

  initial begin
    int n;
    logic [N-1:0] goodTx;
    logic [N-1:0] goodRx;
    logic [N-1:0] badRx;
    goodTx    = {TX_HEADER_DEFAULT, 32'hDEADBEEF};
    goodRx    = {RX_HEADER_DEFAULT, 32'h12345678};
    badRx     = 64'h00000000_CAFEF00D;
    start     = 1'b0;
    tx_data   = '0;
    SPI_MISO  = 1'b0;
    slaveWord = '0;
    slaveIdx  = 0;
    bothCnt   = 0;
    clearCounters();

    // Reset state and an idle bus with no start.
    rst_n = 1'b0;
    #12;
    checkOutput("rst_ssel", 64'(SPI_SSEL), 64'd1);
    checkOutput("rst_sck", 64'(SPI_SCK), 64'd0);
    checkOutput("rst_mosi", 64'(SPI_MOSI), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_flags", {62'd0, done, hdr_err}, 64'd0);
    checkOutput("rst_rx", rx_data, 64'd0);
    @(negedge sysclk);
    rst_n = 1'b1;
    repeat (100) @(posedge sysclk);
    #1;
    checkOutput("idle_sck", 64'(sckRises), 64'd0);
    checkOutput("idle_ssel", 64'(sselFalls), 64'd0);

    // Single good frame.
    $display("[TB] single good frame");
    applyStimulus(goodTx, goodRx, -1, '0);
    checkOutput("good_mosi", mosiCap, goodTx);
    checkOutput("good_sck", 64'(sckRises), 64'd64);
    checkOutput("good_done", 64'(doneCnt), 64'd1);
    checkOutput("good_hdrerr", 64'(hdrErrCnt), 64'd0);
    checkOutput("good_rx", rx_data, goodRx);
    checkOutput("good_ssel_t", 64'(sselCycles), 64'd258);
    checkOutput("good_busy_t", 64'(busyCycles), 64'd4);

    // Bad header: rx_data holds the previous frame.
    $display("[TB] bad header frame");
    applyStimulus(64'h0123456789ABCDEF, badRx, -1, '0);
    checkOutput("bad_mosi", mosiCap, 64'h0123456789ABCDEF);
    checkOutput("bad_hdrerr", 64'(hdrErrCnt), 64'd1);
    checkOutput("bad_done", 64'(doneCnt), 64'd0);
    checkOutput("bad_rx", rx_data, goodRx);

    // Start pulsed mid-frame with different data is ignored.
    $display("[TB] ignored start");
    applyStimulus(64'hA5A5A5A5_0F0F0F0F, goodRx, 100, 64'hFFFF0000_FFFF0000);
    checkOutput("ign_mosi", mosiCap, 64'hA5A5A5A5_0F0F0F0F);
    checkOutput("ign_sck", 64'(sckRises), 64'd64);
    checkOutput("ign_ssel_t", 64'(sselCycles), 64'd258);
    checkOutput("ign_busy_t", 64'(busyCycles), 64'd4);
    repeat (10) @(posedge sysclk);
    #1;
    checkOutput("ign_frames", 64'(sselFalls), 64'd1);
    checkOutput("ign_done", 64'(doneCnt), 64'd1);

    // Asynchronous reset at bit 20.
    $display("[TB] reset mid-frame");
    @(negedge sysclk);
    clearCounters();
    slaveWord = goodRx;
    tx_data   = goodTx;
    start     = 1'b1;
    @(posedge sysclk);
    #1;
    start = 1'b0;
    n = 0;
    while (sckRises < 20 && n < 2000) begin
      @(posedge sysclk);
      #1;
      n++;
    end
    checkOutput("mid_reached", 64'(sckRises), 64'd20);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_ssel", 64'(SPI_SSEL), 64'd1);
    checkOutput("mid_sck", 64'(SPI_SCK), 64'd0);
    checkOutput("mid_busy", 64'(busy), 64'd0);
    @(negedge sysclk);
    rst_n = 1'b1;
    repeat (20) @(posedge sysclk);
    #1;
    checkOutput("mid_pulses", 64'(doneCnt + hdrErrCnt), 64'd0);
    checkOutput("mid_rx", rx_data, 64'd0);
    applyStimulus(goodTx, goodRx, -1, '0);
    checkOutput("post_mosi", mosiCap, goodTx);
    checkOutput("post_sck", 64'(sckRises), 64'd64);
    checkOutput("post_done", 64'(doneCnt), 64'd1);
    checkOutput("post_rx", rx_data, goodRx);
    checkOutput("post_ssel_t", 64'(sselCycles), 64'd258);

`ifdef SPIM_ERRCNT_EN
    // Error counter: three bad frames then one good.
    $display("[TB] error counter");
    checkOutput("ec_start", 64'(err_count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(goodTx, badRx, -1, '0);
    end
    checkOutput("ec_three", 64'(err_count), 64'd3);
    applyStimulus(goodTx, goodRx, -1, '0);
    checkOutput("ec_good", 64'(err_count), 64'd3);
`endif

    checkOutput("never_both", 64'(bothCnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
